// File: rtl/mips_run_ctrl_pkg.sv
// mips_run_ctrl_pkg: run-controller state and result encodings
package mips_run_ctrl_pkg;
  typedef enum logic [1:0] {RUN_IDLE, RUN_RESET, RUN_RUN, RUN_DONE} run_state_t;
  typedef enum logic [1:0] {ST_NONE, ST_HALTED, ST_TIMEOUT, ST_ABORTED} run_status_t;
endpackage

// File: rtl/mips_halt_detect.sv
// mips_halt_detect: flags a PC self-loop held for HALT_WINDOW unstalled cycles
module mips_halt_detect #(
  parameter int PC_WIDTH    = 8,
  parameter int HALT_WINDOW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                capture_i,
  input  logic                count_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                stall_n_i,
  output logic                halted_o
);
  localparam int HW = $clog2(HALT_WINDOW);
  logic [PC_WIDTH-1:0] pc_q;
  logic [HW-1:0]       cnt_q;
  logic                same;
  assign same     = (pc_i == pc_q) && stall_n_i;
  // the count holds matches, so HALT_WINDOW identical PCs need HALT_WINDOW-1 matches
  assign halted_o = count_i && same && (cnt_q == HW'(HALT_WINDOW - 2));
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (capture_i) pc_q <= pc_i;
      if (clear_i) cnt_q <= '0;
      else if (count_i) cnt_q <= same ? cnt_q + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: reset sequencing, clock gating and run supervision for the MIPS-16 core
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int RST_CYCLES  = 4,
  parameter int HALT_WINDOW = 8,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 pipeline_stall_n,
  input  logic                 reg_write_en,
  output logic                 core_rst,
  output logic                 clk_en,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retire_count
);
  localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  run_state_t           state_q, state_d;
  run_status_t          status_q, status_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, ret_q, ret_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic                 launch, halted;
  assign launch = start && (state_q == RUN_IDLE || state_q == RUN_DONE);
  mips_halt_detect #(.PC_WIDTH(PC_WIDTH), .HALT_WINDOW(HALT_WINDOW)) u_halt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (launch),
    .capture_i (state_q == RUN_RESET || state_q == RUN_RUN),
    .count_i   (state_q == RUN_RUN),
    .pc_i      (pc),
    .stall_n_i (pipeline_stall_n),
    .halted_o  (halted)
  );
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cyc_d    = cyc_q;
    ret_d    = ret_q;
    rcnt_d   = rcnt_q;
    case (state_q)
      RUN_IDLE, RUN_DONE: if (start) begin
        state_d  = RUN_RESET;
        status_d = ST_NONE;
        cyc_d    = '0;
        ret_d    = '0;
        rcnt_d   = '0;
      end
      RUN_RESET: begin
        if (abort) begin
          state_d  = RUN_DONE;
          status_d = ST_ABORTED;
        end else if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = RUN_RUN;
        else rcnt_d = rcnt_q + 1'b1;
      end
      RUN_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (reg_write_en && ret_q != '1) ret_d = ret_q + 1'b1;
        if (abort) begin
          state_d  = RUN_DONE;
          status_d = ST_ABORTED;
        end else if (halted) begin
          state_d  = RUN_DONE;
          status_d = ST_HALTED;
        end else if (cyc_q == CNT_WIDTH'(MAX_CYCLES - 1)) begin
          state_d  = RUN_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      default: state_d = RUN_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN_IDLE;
      status_q <= ST_NONE;
      cyc_q    <= '0;
      ret_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
      rcnt_q   <= rcnt_d;
    end
  end
  assign core_rst     = state_q == RUN_IDLE || state_q == RUN_RESET;
  assign clk_en       = state_q == RUN_RESET || state_q == RUN_RUN;
  assign busy         = clk_en;
  assign done         = state_q == RUN_DONE;
  assign status       = status_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: scenario tasks plus randomized traffic against a cycle-level behavioural model
module tb_mips_run_ctrl;
  localparam int RC = 4, HW = 8, MAXC = 1024;
  localparam int M_IDLE = 0, M_RST = 1, M_RUN = 2, M_DONE = 3;
  logic clk = 1'b0;
  logic rst, start, abort, stall_n, we;
  logic [7:0] pc;
  logic core_rst, clk_en, busy, done;
  logic [1:0] status;
  logic [15:0] cycle_count, retire_count;
  int n_cmp = 0, n_bad = 0;
  int m_mode = M_IDLE, m_rleft = 0, m_cyc = 0, m_ret = 0, m_st = 0, m_streak = 0;
  logic [7:0] m_prev = 8'h00;

  mips_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc),
    .pipeline_stall_n(stall_n), .reg_write_en(we),
    .core_rst(core_rst), .clk_en(clk_en), .busy(busy), .done(done),
    .status(status), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] obs();
    return {core_rst, clk_en, busy, done, status, cycle_count, retire_count};
  endfunction

  function automatic logic [37:0] expv();
    logic active;
    active = (m_mode == M_RST) || (m_mode == M_RUN);
    return {m_mode == M_IDLE || m_mode == M_RST, active, active, m_mode == M_DONE,
            2'(m_st), 16'(m_cyc), 16'(m_ret)};
  endfunction

  task automatic tick();
    bit same;
    @(posedge clk);
    if (!rst) begin
      m_mode = M_IDLE; m_cyc = 0; m_ret = 0; m_st = 0; m_streak = 0;
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (start) begin
        m_mode = M_RST; m_rleft = RC; m_cyc = 0; m_ret = 0; m_st = 0; m_streak = 0;
      end
    end else if (m_mode == M_RST) begin
      m_prev = pc;
      if (abort) begin m_mode = M_DONE; m_st = 3; end
      else begin
        m_rleft--;
        if (m_rleft == 0) m_mode = M_RUN;
      end
    end else begin
      same = (pc == m_prev) && stall_n;
      m_streak = same ? m_streak + 1 : 0;
      m_prev = pc;
      m_cyc++;
      if (we && m_ret < 65535) m_ret++;
      if (abort) begin m_mode = M_DONE; m_st = 3; end
      else if (m_streak >= HW - 1) begin m_mode = M_DONE; m_st = 1; end
      else if (m_cyc >= MAXC) begin m_mode = M_DONE; m_st = 2; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pc = 8'h00; stall_n = 1'b1; we = 1'b0;
  endtask

  task automatic go_idle();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic enter_run(input logic [7:0] rst_pc);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && m_mode == M_RST; i++) begin
      pc = rst_pc;
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    start = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs() !== {4'b1000, 2'd0, 16'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_values got %h want %h", obs(), {4'b1000, 2'd0, 16'd0, 16'd0});
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (obs() !== expv()) begin n_bad++; $display("FAIL reset_idle got %h want %h", obs(), expv()); end
  endtask

  task automatic test_basic_start();
    go_idle();
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RC; i++) begin
      n_cmp++;
      if ({core_rst, clk_en, busy} !== 3'b111) begin
        n_bad++;
        $display("FAIL basic_reset_phase cyc%0d got %b want 111", i, {core_rst, clk_en, busy});
      end
      pc = 8'(i + 8'h40);
      tick();
    end
    n_cmp++;
    if ({core_rst, clk_en, busy, done} !== 4'b0110) begin
      n_bad++;
      $display("FAIL basic_run_entry got %b want 0110", {core_rst, clk_en, busy, done});
    end
    n_cmp++;
    if (obs() !== expv()) begin n_bad++; $display("FAIL basic_model got %h want %h", obs(), expv()); end
  endtask

  task automatic test_halt();
    int k;
    go_idle();
    enter_run(8'(8'h80 + $urandom_range(0, 63)));
    for (k = 0; k < 100 && !done; k++) begin
      pc = k < 3 ? 8'(k) : 8'd3;
      stall_n = 1'b1;
      we = 1'($urandom);
      tick();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL halt_cycle%0d got %h want %h", k, obs(), expv()); end
    end
    n_cmp++;
    if (k !== 11) begin n_bad++; $display("FAIL halt_latency got %0d want 11", k); end
    n_cmp++;
    if ({done, clk_en, status, cycle_count} !== {1'b1, 1'b0, 2'd1, 16'd11}) begin
      n_bad++;
      $display("FAIL halt_result got %b/%b/%0d/%0d want 1/0/1/11", done, clk_en, status, cycle_count);
    end
  endtask

  task automatic test_stall_timeout();
    int k;
    go_idle();
    enter_run(8'd5);
    for (k = 0; k < 1100 && !done; k++) begin
      pc = 8'd5;
      stall_n = (k % 4) != 3;
      we = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL stall_cycle%0d got %h want %h", k, obs(), expv()); end
    end
    n_cmp++;
    if ({done, status, cycle_count} !== {1'b1, 2'd2, 16'd1024}) begin
      n_bad++;
      $display("FAIL stall_timeout got %b/%0d/%0d want 1/2/1024", done, status, cycle_count);
    end
  endtask

  task automatic test_abort();
    bit sel [50];
    int picked = 0;
    for (int i = 0; i < 50; i++) sel[i] = 1'b0;
    while (picked < 20) begin
      int j = $urandom_range(0, 49);
      if (!sel[j]) begin sel[j] = 1'b1; picked++; end
    end
    go_idle();
    enter_run(8'hFF);
    for (int k = 0; k < 50; k++) begin
      pc = 8'(k);
      we = sel[k];
      abort = (k == 49);
      tick();
    end
    abort = 1'b0;
    we = 1'b0;
    n_cmp++;
    if ({done, clk_en, status, cycle_count, retire_count} !== {1'b1, 1'b0, 2'd3, 16'd50, 16'd20}) begin
      n_bad++;
      $display("FAIL abort_result got %b/%b/%0d/%0d/%0d want 1/0/3/50/20",
               done, clk_en, status, cycle_count, retire_count);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({done, status} !== {1'b1, 2'd3}) begin n_bad++; $display("FAIL abort_in_done got %b/%0d want 1/3", done, status); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs() !== {4'b1110, 2'd0, 16'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL abort_rerun got %h want %h", obs(), {4'b1110, 2'd0, 16'd0, 16'd0});
    end
  endtask

  task automatic test_reset_midrun();
    go_idle();
    enter_run(8'h11);
    for (int k = 0; k < 29; k++) begin
      pc = 8'(k * 3);
      we = 1'b1;
      tick();
    end
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs() !== {4'b1000, 2'd0, 16'd0, 16'd0}) begin
        n_bad++;
        $display("FAIL midrun_reset%0d got %h want %h", i, obs(), {4'b1000, 2'd0, 16'd0, 16'd0});
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if ({core_rst, clk_en, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL midrun_start_ignored got %b want 100", {core_rst, clk_en, busy});
    end
  endtask

  task automatic test_halt_timeout();
    int k;
    go_idle();
    enter_run(8'h33);
    for (k = 0; k < 1100 && !done; k++) begin
      pc = k < MAXC - HW ? 8'(k) : 8'hF0;
      tick();
    end
    n_cmp++;
    if ({done, status, cycle_count} !== {1'b1, 2'd1, 16'd1024}) begin
      n_bad++;
      $display("FAIL halt_vs_timeout got %b/%0d/%0d want 1/1/1024", done, status, cycle_count);
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int k = 0; k < 3000; k++) begin
      rst = $urandom_range(0, 199) != 0;
      start = $urandom_range(0, 19) == 0;
      abort = $urandom_range(0, 63) == 0;
      pc = 8'($urandom_range(0, 3));
      stall_n = $urandom_range(0, 7) != 0;
      we = 1'($urandom);
      tick();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL random_cycle%0d got %h want %h", k, obs(), expv()); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_start();
    test_halt();
    test_stall_timeout();
    test_abort();
    test_reset_midrun();
    test_halt_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
